// File: rtl/rvv_vl_writeback_arbiter.sv
// rvv_vl_writeback_arbiter
//   Buffers the scalar vl writebacks produced by vsetvl/vsetvli/vsetivli and
//   retires them onto whichever scalar regfile write ports the scalar pipeline
//   leaves idle. Exposes a pending-rd scoreboard and a free-slot count for
//   dispatch.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   vreq_valid_i     per-slot writeback request (N slots, may be sparse)
//   vreq_addr_i      rd per slot
//   vreq_data_i      value per slot
//   port_busy_i      write port p is taken by the scalar pipeline this cycle
//   wr_valid_o       write enable per port
//   wr_addr_o        write address per port
//   wr_data_o        write data per port
//   free_count_o     DEPTH minus registered occupancy
//   pending_mask_o   bit r set while a queued entry targets xr
//   overflow_o       sticky: some request was dropped for lack of room
module rvv_vl_writeback_arbiter #(
    parameter int N       = 4,
    parameter int W       = 2,
    parameter int DEPTH   = 8,
    parameter int CNTBITS = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N-1:0]              vreq_valid_i,
    input  logic [N-1:0][4:0]         vreq_addr_i,
    input  logic [N-1:0][31:0]        vreq_data_i,
    input  logic [W-1:0]              port_busy_i,
    output logic [W-1:0]              wr_valid_o,
    output logic [W-1:0][4:0]         wr_addr_o,
    output logic [W-1:0][31:0]        wr_data_o,
    output logic [CNTBITS-1:0]        free_count_o,
    output logic [31:0]               pending_mask_o,
    output logic                      overflow_o
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]         addr_q [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [PTRW-1:0]    head_q, tail_q;
    logic [CNTBITS-1:0] count_q;
    logic               overflow_q;

    logic [N-1:0]       enq_we;
    logic [PTRW-1:0]    enq_pos [N];
    logic               drop;
    logic [PTRW-1:0]    head_nxt, tail_nxt;
    logic [CNTBITS-1:0] count_nxt;

    // Issue: entries leave strictly in order. The walk stops at the first
    // entry whose rd was already written this cycle, so two writes to the
    // same register never land in one cycle and the youngest value wins.
    always_comb begin
        int         n_iss;
        int         idx;
        int         h;
        logic       stop;
        logic [31:0] seen;
        wr_valid_o = '0;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        n_iss      = 0;
        idx        = 0;
        stop       = 1'b0;
        seen       = '0;
        for (int p = 0; p < W; p++) begin
            if (!port_busy_i[p] && !stop) begin
                if (n_iss >= int'(count_q)) begin
                    stop = 1'b1;
                end else begin
                    idx = int'(head_q) + n_iss;
                    if (idx >= DEPTH) idx = idx - DEPTH;
                    if (seen[addr_q[idx]]) begin
                        stop = 1'b1;
                    end else begin
                        wr_valid_o[p]     = 1'b1;
                        wr_addr_o[p]      = addr_q[idx];
                        wr_data_o[p]      = data_q[idx];
                        seen[addr_q[idx]] = 1'b1;
                        n_iss             = n_iss + 1;
                    end
                end
            end
        end

        // Enqueue: room is judged before this cycle's dequeue, so issuing
        // never makes space for a same-cycle request.
        begin
            int room;
            int acc;
            int pos;
            room   = DEPTH - int'(count_q);
            acc    = 0;
            pos    = 0;
            drop   = 1'b0;
            enq_we = '0;
            for (int s = 0; s < N; s++) begin
                enq_pos[s] = '0;
                if (vreq_valid_i[s] && (vreq_addr_i[s] != 5'd0)) begin
                    if (acc < room) begin
                        pos = int'(tail_q) + acc;
                        if (pos >= DEPTH) pos = pos - DEPTH;
                        enq_we[s]  = 1'b1;
                        enq_pos[s] = PTRW'(pos);
                        acc        = acc + 1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end

            h = int'(head_q) + n_iss;
            if (h >= DEPTH) h = h - DEPTH;
            head_nxt = PTRW'(h);
            pos = int'(tail_q) + acc;
            if (pos >= DEPTH) pos = pos - DEPTH;
            tail_nxt  = PTRW'(pos);
            count_nxt = CNTBITS'(int'(count_q) + acc - n_iss);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int s = 0; s < N; s++) begin
                if (enq_we[s]) begin
                    addr_q[enq_pos[s]] <= vreq_addr_i[s];
                    data_q[enq_pos[s]] <= vreq_data_i[s];
                end
            end
            head_q  <= head_nxt;
            tail_q  <= tail_nxt;
            count_q <= count_nxt;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Scoreboard covers only entries already in the FIFO (registered state).
    always_comb begin
        int idx;
        idx            = 0;
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count_q)) begin
                idx = int'(head_q) + i;
                if (idx >= DEPTH) idx = idx - DEPTH;
                pending_mask_o[addr_q[idx]] = 1'b1;
            end
        end
        pending_mask_o[0] = 1'b0;
    end

    assign free_count_o = CNTBITS'(DEPTH) - count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_rvv_vl_writeback_arbiter.sv
module tb_rvv_vl_writeback_arbiter;

    localparam int N = 4;
    localparam int W = 2;
    localparam int DEPTH = 8;
    localparam int CNTBITS = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [N-1:0]         vreq_valid_i = '0;
    logic [N-1:0][4:0]    vreq_addr_i = '0;
    logic [N-1:0][31:0]   vreq_data_i = '0;
    logic [W-1:0]         port_busy_i = '0;
    logic [W-1:0]         wr_valid_o;
    logic [W-1:0][4:0]    wr_addr_o;
    logic [W-1:0][31:0]   wr_data_o;
    logic [CNTBITS-1:0]   free_count_o;
    logic [31:0]          pending_mask_o;
    logic                 overflow_o;

    rvv_vl_writeback_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .vreq_valid_i   (vreq_valid_i),
        .vreq_addr_i    (vreq_addr_i),
        .vreq_data_i    (vreq_data_i),
        .port_busy_i    (port_busy_i),
        .wr_valid_o     (wr_valid_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .free_count_o   (free_count_o),
        .pending_mask_o (pending_mask_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];          // model FIFO contents
    ent_t obs_log[$];    // writes actually seen on the DUT ports
    logic m_ovf;
    int   nchecks = 0;
    int   nerr = 0;

    // last sampled DUT outputs, for directed literal checks
    logic [W-1:0]       s_valid;
    logic [W-1:0][4:0]  s_addr;
    logic [W-1:0][31:0] s_data;
    logic [CNTBITS-1:0] s_free;
    logic [31:0]        s_pend;
    logic               s_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare against the model mid-cycle, then let
    // the model absorb the clock edge. Called at posedge+1.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0][4:0] a,
                        input logic [N-1:0][31:0] d, input logic [W-1:0] busy);
        logic [W-1:0]       ev;
        logic [W-1:0][4:0]  ea;
        logic [W-1:0][31:0] ed;
        logic [31:0]        seen;
        logic [31:0]        epend;
        int                 n;
        int                 room;
        logic               stop;
        vreq_valid_i = v;
        vreq_addr_i  = a;
        vreq_data_i  = d;
        port_busy_i  = busy;
        @(negedge clk);

        ev = '0; ea = '0; ed = '0; seen = '0; n = 0; stop = 1'b0;
        for (int p = 0; p < W; p++) begin
            if (!busy[p] && !stop) begin
                if (n >= q.size()) stop = 1'b1;
                else if (seen[q[n].a]) stop = 1'b1;
                else begin
                    ev[p] = 1'b1; ea[p] = q[n].a; ed[p] = q[n].d;
                    seen[q[n].a] = 1'b1;
                    n++;
                end
            end
        end
        epend = '0;
        foreach (q[i]) epend[q[i].a] = 1'b1;
        epend[0] = 1'b0;

        s_valid = wr_valid_o; s_addr = wr_addr_o; s_data = wr_data_o;
        s_free = free_count_o; s_pend = pending_mask_o; s_ovf = overflow_o;
        chk("wr_valid", 64'(s_valid), 64'(ev));
        chk("wr_addr", 64'(s_addr), 64'(ea));
        chk("wr_data", 64'(s_data), 64'(ed));
        chk("free_count", 64'(s_free), 64'(DEPTH - q.size()));
        chk("pending_mask", 64'(s_pend), 64'(epend));
        chk("overflow", 64'(s_ovf), 64'(m_ovf));
        for (int p = 0; p < W; p++)
            if (s_valid[p]) obs_log.push_back(ent_t'({s_addr[p], s_data[p]}));

        @(posedge clk);
        room = DEPTH - q.size();
        for (int i = 0; i < n; i++) void'(q.pop_front());
        for (int s = 0; s < N; s++) begin
            if (v[s] && a[s] != 5'd0) begin
                if (room > 0) begin
                    q.push_back(ent_t'({a[s], d[s]}));
                    room--;
                end else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [W-1:0] busy);
        step('0, '0, '0, busy);
    endtask

    task automatic do_reset();
        vreq_valid_i = '0;
        port_busy_i  = '0;
        rstn = 1'b0;
        #1;
        chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        chk("rst_wr_data", 64'(wr_data_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        q.delete();
        obs_log.delete();
        m_ovf = 1'b0;
        #1;
        chk("rst_free", 64'(free_count_o), 64'(DEPTH));
        chk("rst_pend", 64'(pending_mask_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
    endtask

    initial begin
        logic [N-1:0][4:0]  a;
        logic [N-1:0][31:0] d;
        logic [N-1:0]       v;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: basic latency
        a = '0; d = '0; a[2] = 5'd5; d[2] = 32'd16;
        step(4'b0100, a, d, 2'b00);
        chk("t1_c0_pend", 64'(s_pend), 64'd0);
        idle(2'b00);
        chk("t1_c1_valid0", 64'(s_valid[0]), 64'd1);
        chk("t1_c1_addr0", 64'(s_addr[0]), 64'd5);
        chk("t1_c1_data0", 64'(s_data[0]), 64'd16);
        chk("t1_c1_pend5", 64'(s_pend[5]), 64'd1);
        idle(2'b00);
        chk("t1_c2_pend", 64'(s_pend), 64'd0);
        chk("t1_c2_free", 64'(s_free), 64'd8);

        // 2: compaction and port sharing
        do_reset();
        a = '0; d = '0;
        a[0] = 5'd1; a[1] = 5'd2; a[3] = 5'd3;
        d[0] = 32'h11; d[1] = 32'h22; d[3] = 32'h33;
        step(4'b1011, a, d, 2'b00);
        for (int c = 1; c <= 4; c++) begin
            idle(2'b01);
            chk("t2_free", 64'(s_free), 64'(4 + c));
            if (c <= 3) begin
                chk("t2_valid", 64'(s_valid), 64'b10);
                chk("t2_addr1", 64'(s_addr[1]), 64'(c));
            end
        end

        // 3: same-rd hazard
        do_reset();
        a = '0; d = '0; a[0] = 5'd7; a[1] = 5'd7; d[0] = 32'd4; d[1] = 32'd8;
        step(4'b0011, a, d, 2'b00);
        idle(2'b00);
        chk("t3_c1_valid", 64'(s_valid), 64'b01);
        chk("t3_c1_data", 64'(s_data[0]), 64'd4);
        chk("t3_c1_pend7", 64'(s_pend[7]), 64'd1);
        idle(2'b00);
        chk("t3_c2_valid", 64'(s_valid), 64'b01);
        chk("t3_c2_data", 64'(s_data[0]), 64'd8);
        chk("t3_c2_pend7", 64'(s_pend[7]), 64'd1);
        idle(2'b00);
        chk("t3_c3_pend7", 64'(s_pend[7]), 64'd0);

        // 4: overflow
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < N; s++) begin
                a[s] = 5'(c * 4 + s + 1);
                d[s] = 32'(16 * (c * 4 + s + 1));
            end
            step(4'b1111, a, d, 2'b11);
            chk("t4_free", 64'(s_free), 64'(8 - 4 * c));
        end
        for (int c = 0; c < 6; c++) begin
            idle(2'b00);
            if (c == 0) chk("t4_ovf_c3", 64'(s_ovf), 64'd1);
        end
        chk("t4_ovf_end", 64'(s_ovf), 64'd1);
        chk("t4_nwrites", 64'(obs_log.size()), 64'd8);
        for (int i = 0; i < obs_log.size() && i < 8; i++)
            chk("t4_order", 64'(obs_log[i].a), 64'(i + 1));

        // 5: x0 filter
        do_reset();
        for (int s = 0; s < N; s++) begin a[s] = 5'd0; d[s] = 32'(s + 9); end
        step(4'b1111, a, d, 2'b00);
        idle(2'b00);
        chk("t5_valid", 64'(s_valid), 64'd0);
        chk("t5_free", 64'(s_free), 64'd8);
        chk("t5_ovf", 64'(s_ovf), 64'd0);

        // 6: wrap and reset
        do_reset();
        for (int c = 0; c < 10; c++) begin
            a = '0; d = '0;
            a[1] = 5'(2 * c + 1); d[1] = 32'(1000 + 2 * c);
            a[2] = 5'(2 * c + 2); d[2] = 32'(1001 + 2 * c);
            step(4'b0110, a, d, 2'b00);
        end
        repeat (3) idle(2'b00);
        chk("t6_nwrites", 64'(obs_log.size()), 64'd20);
        for (int i = 0; i < obs_log.size() && i < 20; i++)
            chk("t6_order", 64'(obs_log[i].d), 64'(1000 + i));
        a = '0; d = '0; a[0] = 5'd3; a[1] = 5'd4; a[2] = 5'd5;
        step(4'b0111, a, d, 2'b11);
        idle(2'b11);
        chk("t6_free_before_rst", 64'(s_free), 64'd5);
        port_busy_i = 2'b00;
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(wr_valid_o), 64'd0);
        @(posedge clk);
        #1;
        do_reset();

        // randomized phase
        for (int c = 0; c < 2000; c++) begin
            for (int s = 0; s < N; s++) begin
                a[s] = 5'($urandom_range(0, 9));
                d[s] = $urandom;
            end
            v = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 1) == 0) v = N'($urandom);
            step(v, a, d, W'($urandom));
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
